// File: rtl/onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports (A = HPS bridge, B = audio engine).
// Byte-lane writes, 1- or 2-stage read pipeline, explicit same-address collision handling.
module onchip_ram_dp #(
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  ADDR_WIDTH   = 13,
    parameter int unsigned  DEPTH        = 8192,
    parameter int unsigned  READ_LATENCY = 1,
    parameter string        INIT_FILE    = "onchip_ram_dp.hex",
    localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,

    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [BE_WIDTH-1:0]   a_byteenable,
    input  logic [DATA_WIDTH-1:0] a_writedata,
    output logic [DATA_WIDTH-1:0] a_readdata,
    output logic                  a_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [BE_WIDTH-1:0]   b_byteenable,
    input  logic [DATA_WIDTH-1:0] b_writedata,
    output logic [DATA_WIDTH-1:0] b_readdata,
    output logic                  b_readdatavalid
);

    localparam int unsigned         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

    // Index 0 is port A, index 1 is port B.
    logic                  w_en;
    logic [1:0]            w_cs;
    logic [1:0]            w_rd;
    logic [1:0]            w_wr;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [BE_WIDTH-1:0]   w_be    [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic [MEM_AW-1:0]     w_idx   [2];
    logic [1:0]            w_in_range;
    logic [1:0]            w_we;
    logic [1:0]            w_re;
    logic [1:0]            w_vout;
    logic [DATA_WIDTH-1:0] w_dout  [2];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]            r_v1;
    logic [DATA_WIDTH-1:0] r_d1 [2];

    assign w_en       = clken & ~reset_req & ~reset;
    assign w_cs       = {b_chipselect, a_chipselect};
    assign w_rd       = {b_read, a_read};
    assign w_wr       = {b_write, a_write};
    assign w_addr[0]  = a_address;
    assign w_addr[1]  = b_address;
    assign w_be[0]    = a_byteenable;
    assign w_be[1]    = b_byteenable;
    assign w_wdata[0] = a_writedata;
    assign w_wdata[1] = b_writedata;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_idx[p]      = w_addr[p][MEM_AW-1:0];
            w_in_range[p] = ({1'b0, w_addr[p]} < DEPTH_CMP);
            w_we[p]       = w_cs[p] & w_wr[p] & w_en & w_in_range[p];
            w_re[p]       = w_cs[p] & w_rd[p] & ~w_wr[p] & w_en;
        end
    end

    // Port B is applied first so port A's lanes override it on a same-address dual write.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (w_we[p]) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (w_be[p][i]) begin
                        r_mem[w_idx[p]][8*i +: 8] <= w_wdata[p][8*i +: 8];
                    end
                end
            end
        end
    end

    // Array read samples pre-write contents, so a cross-port same-cycle read returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= '0;
            for (int p = 0; p < 2; p++) begin
                r_d1[p] <= '0;
            end
        end else if (w_en) begin
            for (int p = 0; p < 2; p++) begin
                r_v1[p] <= w_re[p];
                if (w_re[p]) begin
                    r_d1[p] <= w_in_range[p] ? r_mem[w_idx[p]] : '0;
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]            r_v2;
        logic [DATA_WIDTH-1:0] r_d2 [2];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_v2 <= '0;
                for (int p = 0; p < 2; p++) begin
                    r_d2[p] <= '0;
                end
            end else if (w_en) begin
                for (int p = 0; p < 2; p++) begin
                    r_v2[p] <= r_v1[p];
                    if (r_v1[p]) begin
                        r_d2[p] <= r_d1[p];
                    end
                end
            end
        end

        assign w_vout = r_v2;
        assign w_dout = r_d2;
    end else begin : g_lat1
        assign w_vout = r_v1;
        assign w_dout = r_d1;
    end

    // A beat held during a stall is shown only once enable returns.
    assign a_readdata      = w_dout[0];
    assign a_readdatavalid = w_vout[0] & w_en;
    assign b_readdata      = w_dout[1];
    assign b_readdatavalid = w_vout[1] & w_en;

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Directed bench: DUT1 (latency 1, DEPTH 6000) and DUT2 (latency 2, DEPTH 8192) share stimulus.
// Table rows cover the main function; hand sequences cover stall and reset corner cases.
module tb_onchip_ram_dp;

    localparam logic [1:0] OP_N  = 2'b00;
    localparam logic [1:0] OP_R  = 2'b01;
    localparam logic [1:0] OP_W  = 2'b10;
    localparam logic [1:0] OP_RW = 2'b11;

    typedef struct {
        logic [1:0]  a_op;
        int          a_addr;
        logic [3:0]  a_be;
        logic [31:0] a_wd;
        logic [1:0]  b_op;
        int          b_addr;
        logic [3:0]  b_be;
        logic [31:0] b_wd;
        logic        a_v;
        logic [31:0] a_d;
        logic        b_v;
        logic [31:0] b_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset_req;
    logic        clken;
    logic [12:0] a_address;
    logic        a_chipselect;
    logic        a_read;
    logic        a_write;
    logic [3:0]  a_byteenable;
    logic [31:0] a_writedata;
    logic [12:0] b_address;
    logic        b_chipselect;
    logic        b_read;
    logic        b_write;
    logic [3:0]  b_byteenable;
    logic [31:0] b_writedata;
    logic [31:0] a_rd1, b_rd1, a_rd2, b_rd2;
    logic        a_rv1, b_rv1, a_rv2, b_rv2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onchip_ram_dp #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (13),
        .DEPTH       (6000),
        .READ_LATENCY(1),
        .INIT_FILE   ("")
    ) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .reset_req      (reset_req),
        .clken          (clken),
        .a_address      (a_address),
        .a_chipselect   (a_chipselect),
        .a_read         (a_read),
        .a_write        (a_write),
        .a_byteenable   (a_byteenable),
        .a_writedata    (a_writedata),
        .a_readdata     (a_rd1),
        .a_readdatavalid(a_rv1),
        .b_address      (b_address),
        .b_chipselect   (b_chipselect),
        .b_read         (b_read),
        .b_write        (b_write),
        .b_byteenable   (b_byteenable),
        .b_writedata    (b_writedata),
        .b_readdata     (b_rd1),
        .b_readdatavalid(b_rv1)
    );

    onchip_ram_dp #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (13),
        .DEPTH       (8192),
        .READ_LATENCY(2),
        .INIT_FILE   ("")
    ) u_dut2 (
        .clk            (clk),
        .reset          (reset),
        .reset_req      (reset_req),
        .clken          (clken),
        .a_address      (a_address),
        .a_chipselect   (a_chipselect),
        .a_read         (a_read),
        .a_write        (a_write),
        .a_byteenable   (a_byteenable),
        .a_writedata    (a_writedata),
        .a_readdata     (a_rd2),
        .a_readdatavalid(a_rv2),
        .b_address      (b_address),
        .b_chipselect   (b_chipselect),
        .b_read         (b_read),
        .b_write        (b_write),
        .b_byteenable   (b_byteenable),
        .b_writedata    (b_writedata),
        .b_readdata     (b_rd2),
        .b_readdatavalid(b_rv2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] aop, input int aad, input logic [3:0] abe,
                         input logic [31:0] awd, input logic [1:0] bop, input int bad,
                         input logic [3:0] bbe, input logic [31:0] bwd);
        a_chipselect = |aop;
        a_write      = aop[1];
        a_read       = aop[0];
        a_address    = aad[12:0];
        a_byteenable = abe;
        a_writedata  = awd;
        b_chipselect = |bop;
        b_write      = bop[1];
        b_read       = bop[0];
        b_address    = bad[12:0];
        b_byteenable = bbe;
        b_writedata  = bwd;
    endtask

    task automatic idle();
        drive(OP_N, 0, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] aop, input int aad, input logic [3:0] abe,
                                input logic [31:0] awd, input logic [1:0] bop, input int bad,
                                input logic [3:0] bbe, input logic [31:0] bwd,
                                input logic av, input logic [31:0] ad,
                                input logic bv, input logic [31:0] bd);
        vec_t v;
        v.a_op = aop; v.a_addr = aad; v.a_be = abe; v.a_wd = awd;
        v.b_op = bop; v.b_addr = bad; v.b_be = bbe; v.b_wd = bwd;
        v.a_v = av; v.a_d = ad; v.b_v = bv; v.b_d = bd;
        return v;
    endfunction

    vec_t vecs [14];

    // Stall pattern for the latency-2 burst: per-cycle clken, reset_req, B op/addr, expected valid.
    logic [10:0] st_ck  = 11'b111_1110_0011;
    logic [10:0] st_rq  = 11'b000_0000_1000;
    logic [10:0] st_exp = 11'b001_1110_0000;

    initial begin
        vecs[0]  = mk(OP_W, 5, 4'hF, 32'hDEADBEEF, OP_W, 9, 4'hF, 32'h11223344, 0, 0, 0, 0);
        vecs[1]  = mk(OP_R, 5, 4'h0, 32'h0, OP_W, 7, 4'hF, 32'h00000000, 0, 0, 0, 0);
        vecs[2]  = mk(OP_N, 0, 4'h0, 32'h0, OP_W, 9, 4'b0101, 32'hAABBCCDD,
                      1, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(OP_R, 9, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 0, 0, 0, 0);
        vecs[4]  = mk(OP_W, 7, 4'b0001, 32'h000000FF, OP_W, 7, 4'b0011, 32'h0000EE00,
                      1, 32'h11BB33DD, 0, 0);
        vecs[5]  = mk(OP_R, 7, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 0, 0, 0, 0);
        vecs[6]  = mk(OP_W, 7, 4'hF, 32'h12345678, OP_R, 7, 4'h0, 32'h0,
                      1, 32'h0000EEFF, 0, 0);
        vecs[7]  = mk(OP_RW, 5, 4'hF, 32'h55555555, OP_R, 7, 4'h0, 32'h0,
                      0, 0, 1, 32'h0000EEFF);
        vecs[8]  = mk(OP_R, 5, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 0, 0, 1, 32'h12345678);
        vecs[9]  = mk(OP_W, 7000, 4'hF, 32'hCAFEF00D, OP_W, 5999, 4'hF, 32'h5A5A5A5A,
                      1, 32'h55555555, 0, 0);
        vecs[10] = mk(OP_R, 7000, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 0, 0, 0, 0);
        vecs[11] = mk(OP_R, 5999, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 1, 32'h00000000, 0, 0);
        vecs[12] = mk(OP_N, 0, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 1, 32'h5A5A5A5A, 0, 0);
        vecs[13] = mk(OP_N, 0, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0, 0, 0, 0, 0);

        reset     = 1'b1;
        reset_req = 1'b0;
        clken     = 1'b1;
        idle();
        tick();
        tick();
        #3;
        check("reset a_valid1", 32'(a_rv1), 32'd0);
        check("reset b_valid2", 32'(b_rv2), 32'd0);
        check("reset a_data1", a_rd1, 32'h0);
        check("reset b_data2", b_rd2, 32'h0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].a_op, vecs[i].a_addr, vecs[i].a_be, vecs[i].a_wd,
                  vecs[i].b_op, vecs[i].b_addr, vecs[i].b_be, vecs[i].b_wd);
            #3;
            check($sformatf("row%0d a_valid", i), 32'(a_rv1), 32'(vecs[i].a_v));
            check($sformatf("row%0d b_valid", i), 32'(b_rv1), 32'(vecs[i].b_v));
            if (vecs[i].a_v) check($sformatf("row%0d a_data", i), a_rd1, vecs[i].a_d);
            if (vecs[i].b_v) check($sformatf("row%0d b_data", i), b_rd1, vecs[i].b_d);
            tick();
        end

        // Latency-2 burst on port B with stalls after the second accept.
        for (int k = 0; k < 4; k++) begin
            drive(OP_N, 0, 4'h0, 32'h0, OP_W, k, 4'hF, 32'hA0 + 32'(k));
            tick();
        end
        idle();
        tick();
        begin
            int beats = 0;
            for (int c = 0; c < 11; c++) begin
                int rd_addr;
                clken     = st_ck[c];
                reset_req = st_rq[c];
                rd_addr   = (c < 2) ? c : (c < 6) ? 2 : 3;
                if (c < 7) drive(OP_N, 0, 4'h0, 32'h0, OP_R, rd_addr, 4'h0, 32'h0);
                else       idle();
                #3;
                check($sformatf("burst c%0d b_valid", c), 32'(b_rv2), 32'(st_exp[c]));
                if (b_rv2) begin
                    if (beats < 4) check($sformatf("burst beat%0d data", beats), b_rd2,
                                         32'hA0 + 32'(beats));
                    beats++;
                end
                tick();
            end
            check("burst beat count", 32'(beats), 32'd4);
        end
        clken     = 1'b1;
        reset_req = 1'b0;

        // Reset with reads in flight; write during reset must be dropped.
        drive(OP_R, 5, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0);
        tick();
        drive(OP_R, 9, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0);
        #3;
        check("pre-reset a_valid1", 32'(a_rv1), 32'd1);
        check("pre-reset a_data1", a_rd1, 32'h55555555);
        tick();
        reset = 1'b1;
        drive(OP_W, 5, 4'hF, 32'hBAD0BAD0, OP_N, 0, 4'h0, 32'h0);
        #3;
        check("in-reset a_valid1", 32'(a_rv1), 32'd0);
        check("in-reset a_valid2", 32'(a_rv2), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        for (int c = 0; c < 2; c++) begin
            #3;
            check($sformatf("post-reset%0d a_valid1", c), 32'(a_rv1), 32'd0);
            check($sformatf("post-reset%0d a_valid2", c), 32'(a_rv2), 32'd0);
            if (c == 0) check("post-reset a_data1", a_rd1, 32'h0);
            tick();
        end
        drive(OP_R, 5, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0);
        tick();
        drive(OP_R, 9, 4'h0, 32'h0, OP_N, 0, 4'h0, 32'h0);
        #3;
        check("kept a_valid1 addr5", 32'(a_rv1), 32'd1);
        check("kept a_data1 addr5", a_rd1, 32'h55555555);
        tick();
        idle();
        #3;
        check("kept a_valid1 addr9", 32'(a_rv1), 32'd1);
        check("kept a_data1 addr9", a_rd1, 32'h11BB33DD);
        check("kept a_valid2 addr5", 32'(a_rv2), 32'd1);
        check("kept a_data2 addr5", a_rd2, 32'h55555555);
        tick();
        #3;
        check("kept a_valid2 addr9", 32'(a_rv2), 32'd1);
        check("kept a_data2 addr9", a_rd2, 32'h11BB33DD);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onchip_ram_dp.md
Name: onchip_ram_dp

Overview:
Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 (port A) and s2 (port B). It provides configurable data width and depth, byte-lane writes, and 1- or 2-cycle pipelined reads that signal completion with readdatavalid. It also defines behaviour for same-address collisions between the ports. It holds audio sample buffers shared between the HPS bridge (s1) and the audio streaming engine (s2).

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 13, word-address width of both ports.
DEPTH, 8192, number of words; must satisfy DEPTH <= 2^ADDR_WIDTH.
READ_LATENCY, 1, read pipeline depth; legal values are 1 and 2.
INIT_FILE, "onchip_ram_dp.hex", memory initialisation file; an empty string means contents are undefined (simulation: X).
BE_WIDTH, DATA_WIDTH/8, derived byte-enable width; not overridable.

Ports:
clk  in  1  single clock for both ports.
reset  in  1  synchronous, active-high reset.
reset_req  in  1  early reset request; when high, the block is stalled like clken=0.
clken  in  1  global clock enable.
a_address  in  ADDR_WIDTH  port A word address.
a_chipselect  in  1  port A select.
a_read  in  1  port A read request.
a_write  in  1  port A write request.
a_byteenable  in  BE_WIDTH  port A write lane enables.
a_writedata  in  DATA_WIDTH  port A write data.
a_readdata  out  DATA_WIDTH  port A read data.
a_readdatavalid  out  1  port A read-data qualifier.
b_address, b_chipselect, b_read, b_write, b_byteenable, b_writedata, b_readdata, b_readdatavalid: same as port A, for port B.

Behaviour:
- Effective enable: en = clken & ~reset_req & ~reset.
- Memory array is never cleared by reset; contents persist across reset.
- Reset values: x_readdata = 0, x_readdatavalid = 0, all read-pipeline valid bits = 0.
- Write accept: chipselect & write & en & (address < DEPTH).
  - Only lanes with byteenable[i] = 1 are updated; other lanes keep their old value.
  - Writes to address >= DEPTH are dropped silently.
- Read accept: chipselect & read & ~write & en.
  - If read and write are asserted together on one port, the write is performed and the read is ignored; no readdatavalid is produced for it.
- Read latency: a read accepted in cycle T gives readdatavalid = 1 and valid readdata in cycle T+READ_LATENCY, provided en stays high.
  - Reads are fully pipelined: one accepted read per cycle gives one valid beat per cycle.
- Out-of-range read (address >= DEPTH): still produces readdatavalid, with readdata = 0.
- Stall (en = 0):
  - No memory access, no new read accepted, pipeline stages hold.
  - x_readdatavalid is forced to 0 during the stall; readdata holds its value.
  - A pending beat is presented exactly once, in the first cycle en returns high. No beat is duplicated or lost.
- readdata when readdatavalid = 0: holds the last valid value. The bench must not check it.
- Same-port read-after-write: a read accepted in the cycle after a write to that address returns the new data.
- Mixed-port read/write same address, same cycle: the reading port returns the OLD data. The write still completes.
- Dual write, same address, same cycle: per lane, port A wins where both enable the lane; port B's data lands only in lanes enabled by B alone.
- Reset mid-operation:
  - In-flight reads are discarded; no readdatavalid appears after reset.
  - A write presented in a reset cycle is not performed.
  - First legal access is the cycle after reset deasserts.
- Target RAM style: inferred true-dual-port block RAM with an output register stage when READ_LATENCY = 2. The collision rules above are implemented explicitly in logic, not left to the vendor primitive.

Test Plan:
1. READ_LATENCY=1, DATA_WIDTH=32: A writes 0xDEADBEEF to addr 5, then A reads addr 5 -> a_readdatavalid high exactly 1 cycle after the read is accepted, a_readdata = 0xDEADBEEF.
2. Byte lanes: word 0x11223344 at addr 9; B writes 0xAABBCCDD with be=0101 -> a later read returns 0x11BB33DD.
3. Collisions, addr 7 holds 0x0:
   - A writes 0x000000FF be=0001 while B writes 0x0000EE00 be=0011, same cycle -> addr 7 = 0x0000EEFF.
   - Separately, A writes 0x12345678 while B reads addr 7, same cycle -> B returns the old value.
4. READ_LATENCY=2: 4 back-to-back B reads of addrs 0..3; clken low for 3 cycles after the 2nd accept -> exactly 4 valid beats, in order, none duplicated, and no valid pulse while clken is low.
5. Reset with 2 reads in flight -> no readdatavalid after reset. A write issued in the reset cycle leaves memory unchanged. Pre-reset contents remain readable afterwards.
6. DEPTH=6000, ADDR_WIDTH=13: write to addr 7000 -> a subsequent read of addr 7000 returns 0 with valid; addr 5999 is unaffected.
